// File: rtl/mem_arb_pkg.sv
// Shared constants and port-ID typedef for the memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_NUM_PORTS = 2;
    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_MAX_OUTST = 4;
    localparam int unsigned CNT_W         = 32;

    // Port-ID width: clog2 of the port count, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_ID_W = id_width(DEF_NUM_PORTS);

    typedef logic [DEF_ID_W-1:0] port_id_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of granted port IDs; pointers carry an extra MSB for full/empty.
module mem_arb_id_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop_ok);
        head_o   = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Round-robin arbiter of NUM_PORTS requesters onto one memory port with in-order responses.
// Optional per-port grant counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_OUTST = DEF_MAX_OUTST
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_PORTS-1:0]                req_i,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    addr_i,
    input  logic [NUM_PORTS-1:0]                wr_i,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]    wr_data_i,
    input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]  byte_en_i,
    output logic [NUM_PORTS-1:0]                gnt_o,
    output logic [NUM_PORTS-1:0]                rvalid_o,
    output logic [DATA_W-1:0]                   rd_data_o,
    output logic                                mem_req_o,
    output logic [ADDR_W-1:0]                   mem_addr_o,
    output logic                                mem_wr_o,
    output logic [DATA_W-1:0]                   mem_wr_data_o,
    output logic [DATA_W/8-1:0]                 mem_byte_en_o,
    input  logic                                mem_gnt_i,
    input  logic                                mem_rvalid_i,
    input  logic [DATA_W-1:0]                   mem_rd_data_i,
    output logic                                err_o
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [NUM_PORTS-1:0][CNT_W-1:0]     grant_cnt_o
`endif
);

    localparam int unsigned ID_W = id_width(NUM_PORTS);

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] sel_c;
    logic [ID_W-1:0] head_id;
    int unsigned     rr_idx;
    logic            any_req;
    logic            fifo_full;
    logic            fifo_empty;
    logic            hs;
    logic            pop;
    logic            err_q, err_d;

    // Round-robin pick: first asserted request at or after rr_ptr.
    always_comb begin : arb
        sel_c   = '0;
        any_req = 1'b0;
        rr_idx  = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            rr_idx = (32'(rr_ptr_q) + k) % NUM_PORTS;
            if (!any_req && req_i[ID_W'(rr_idx)]) begin
                any_req = 1'b1;
                sel_c   = ID_W'(rr_idx);
            end
        end
    end

    always_comb begin : next_state
        hs       = any_req && !fifo_full && mem_gnt_i;
        pop      = mem_rvalid_i && !fifo_empty;
        rr_ptr_d = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = ID_W'((32'(sel_c) + 1) % NUM_PORTS);
        end
        err_d = err_q || (mem_rvalid_i && fifo_empty);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    mem_arb_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk         (clk),
        .rst_n       (reset_n),
        .push_i      (hs),
        .push_data_i (sel_c),
        .pop_i       (pop),
        .head_o      (head_id),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Request path is combinational; everything is forced to zero while in reset.
    always_comb begin : out_mux
        gnt_o         = '0;
        rvalid_o      = '0;
        rd_data_o     = '0;
        mem_req_o     = 1'b0;
        mem_addr_o    = '0;
        mem_wr_o      = 1'b0;
        mem_wr_data_o = '0;
        mem_byte_en_o = '0;
        err_o         = 1'b0;
        if (reset_n) begin
            mem_req_o = any_req && !fifo_full;
            if (any_req) begin
                mem_addr_o    = addr_i[sel_c];
                mem_wr_o      = wr_i[sel_c];
                mem_wr_data_o = wr_data_i[sel_c];
                mem_byte_en_o = byte_en_i[sel_c];
            end
            if (hs) begin
                gnt_o = NUM_PORTS'(1) << sel_c;
            end
            if (pop) begin
                rvalid_o = NUM_PORTS'(1) << head_id;
            end
            rd_data_o = mem_rd_data_i;
            err_o     = err_q;
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [NUM_PORTS-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Saturating per-port handshake counters.
    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (gnt_o[p] && (cnt_q[p] != '1)) begin
                cnt_d[p] = cnt_q[p] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 The block SHALL expose parameter NUM_PORTS, 2, number of requester ports (port 0 = instruction, port 1 = data).
REQ-002 The block SHALL expose parameter ADDR_W, 32, address width.
REQ-003 The block SHALL expose parameter DATA_W, 32, data width; the byte-enable width SHALL be DATA_W/8.
REQ-004 The block SHALL expose parameter MAX_OUTST, 4, maximum outstanding memory transactions (power of two, >=2).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_i  in  NUM_PORTS  per-port request.
- addr_i  in  NUM_PORTS x ADDR_W  per-port address.
- wr_i  in  NUM_PORTS  per-port write (1) / read (0).
- wr_data_i  in  NUM_PORTS x DATA_W  per-port write data.
- byte_en_i  in  NUM_PORTS x DATA_W/8  per-port byte strobes.
- gnt_o  out  NUM_PORTS  per-port accept, one-hot or zero.
- rvalid_o  out  NUM_PORTS  per-port response valid, one-hot or zero.
- rd_data_o  out  DATA_W  response data, shared across ports.
- mem_req_o  out  1  memory request.
- mem_addr_o, mem_wr_o, mem_wr_data_o, mem_byte_en_o  out  ADDR_W, 1, DATA_W, DATA_W/8  selected port fields.
- mem_gnt_i  in  1  memory accepts the request.
- mem_rvalid_i  in  1  memory response valid.
- mem_rd_data_i  in  DATA_W  memory response data.
- err_o  out  1  sticky protocol error.

Function
REQ-006 A transfer SHALL occur on any rising edge where mem_req_o and mem_gnt_i are both 1; gnt_o[p] SHALL equal that handshake qualified by selection of port p.
REQ-007 Arbitration SHALL be combinational among asserted req_i, round-robin starting at pointer rr_ptr; after each handshake, rr_ptr SHALL become granted port + 1 modulo NUM_PORTS.
REQ-008 mem_req_o SHALL be 1 iff any req_i is 1 and the ID FIFO is not full; mem_* fields SHALL mux from the selected port with zero added latency.
REQ-009 Each handshake SHALL push the granted port index into an in-order ID FIFO of depth MAX_OUTST.
REQ-010 On mem_rvalid_i with non-empty FIFO, rvalid_o[head ID] SHALL be 1 in the same cycle; rd_data_o SHALL equal mem_rd_data_i; the FIFO SHALL pop.
REQ-011 Writes SHALL also receive one mem_rvalid_i response and occupy a FIFO slot.
REQ-012 Simultaneous push and pop SHALL be legal when the FIFO is non-full; when full, push SHALL be blocked even if a pop occurs in the same cycle.
REQ-013 mem_rvalid_i with an empty FIFO SHALL be ignored for rvalid_o and SHALL set err_o, which stays set until reset.
REQ-014 A requester SHALL hold req_i and its fields stable until gnt_o; a deasserted, never-granted req_i SHALL be dropped without error.
REQ-015 Pointer arithmetic SHALL wrap modulo MAX_OUTST using an extra MSB to distinguish full from empty.

Reset
REQ-016 While reset_n = 0: gnt_o, rvalid_o, mem_req_o, mem_wr_o, mem_byte_en_o, err_o SHALL be 0; mem_addr_o, mem_wr_data_o, rd_data_o SHALL be 0; rr_ptr = 0; FIFO empty.
REQ-017 Reset asserted mid-transaction SHALL discard all outstanding IDs; responses arriving after reset release SHALL set err_o per REQ-013.

Configuration
REQ-018 With MEM_ARB_PERF_CNT_EN defined, the block SHALL add output grant_cnt_o (NUM_PORTS x 32), per-port saturating handshake counters cleared by reset; without it, the port and counters SHALL be absent.

Structure
REQ-019 Package mem_arb_pkg SHALL hold default parameter constants and a typedef for the port-ID type (clog2 of NUM_PORTS, minimum 1 bit).
REQ-020 The ID FIFO SHALL be a separate sub-module named mem_arb_id_fifo, parametrised by width and depth.

Verification
REQ-021 Both ports request continuously with mem_gnt_i = 1 -> grants alternate 0,1,0,1 over 4 cycles.
REQ-022 Four reads are issued with mem_rvalid_i held 0 (MAX_OUTST = 4) -> fifth cycle mem_req_o = 0; one rvalid in the next cycle -> mem_req_o = 1 the following cycle.
REQ-023 Port 0 reads addr 0x100 then port 1 reads 0x200; memory returns 0xAAAA0000 then 0xBBBB0000 -> rvalid_o = 01 with 0xAAAA0000, then 10 with 0xBBBB0000.
REQ-024 mem_rvalid_i pulses while the FIFO is empty -> rvalid_o = 00 and err_o = 1 persisting until reset_n = 0.
REQ-025 reset_n drops with 2 outstanding transactions -> all outputs 0 during reset, FIFO empty after release, and a late rvalid sets err_o.
REQ-026 With MEM_ARB_PERF_CNT_EN, 10 port-1 handshakes -> grant_cnt_o[1] = 10 and grant_cnt_o[0] = 0.
